// File: rtl/rib_arbiter.sv
// rib_arbiter: registered arbiter and transaction sequencer for the RIB bus.
//
// Three masters share one bus path: m0 = ex/mem, m1 = instruction fetch
// (default owner), m2 = JTAG/debug. A grant is held until the addressed
// slave acks. Locked back-to-back transfers are supported, and a watchdog
// forces a release with an error ack when a slave never answers.
//
// Optional feature macro: RIB_ARB_STARVE_GUARD_EN
//   Defined   : per-master 4-bit wait counters. A master that has waited
//               15 cycles wins the next arbitration, and it breaks any lock
//               held by another master at that master's next ack.
//   Undefined : plain fixed-priority or round-robin arbitration.
module rib_arbiter #(
  parameter int PRIO_MODE      = 0,    // 0: fixed m0 > m2 > m1, 1: round-robin
  parameter int TIMEOUT_CYCLES = 256,  // BUSY cycles without ack before release
  parameter int CNT_W          = 16    // watchdog width, must hold TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active low
  input  logic [2:0] m_req_i,
  input  logic [2:0] m_lock_i,
  input  logic       bus_ack_i,
  output logic [1:0] grant_o,
  output logic       grant_vld_o,
  output logic       hold_flag_o,
  output logic [2:0] err_ack_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TOUT = 2'd2
  } state_e;

  localparam logic [1:0]       GRANT_NONE = 2'd3;
  localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [1:0]       grant_q;
  logic             grant_vld_q;
  logic [2:0]       err_ack_q;
  logic             timeout_q;
  logic [CNT_W-1:0] wdog_q;
  logic [1:0]       ptr_q;        // last granted master, round-robin origin

  logic [2:0]       starved;      // masters whose wait counter is saturated
  logic [2:0]       req_others;   // pending requests excluding the owner
  logic             lock_kept;    // owner keeps the bus across this ack
  logic             grant_rel;    // owner finishes or abandons this cycle
  logic             load_en;      // a new winner is loaded at the next edge
  logic [1:0]       load_idx;     // that winner

  // One-hot decode of an encoded master index; GRANT_NONE decodes to zero.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Successor of a master index in the ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ring_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Fixed priority order m0, m2, m1.
  function automatic logic [1:0] pick_fixed(input logic [2:0] req);
    if (req[0]) return 2'd0;
    if (req[2]) return 2'd2;
    if (req[1]) return 2'd1;
    return GRANT_NONE;
  endfunction

  // Round-robin: search starts just after the last granted master.
  function automatic logic [1:0] pick_rr(input logic [2:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = ring_next(ptr);
    c2 = ring_next(c1);
    if (req[c1])  return c1;
    if (req[c2])  return c2;
    if (req[ptr]) return ptr;
    return GRANT_NONE;
  endfunction

  // Starved requesters win first (lowest index), otherwise the configured
  // policy decides.
  function automatic logic [1:0] arbitrate(input logic [2:0] req,
                                           input logic [1:0] ptr,
                                           input logic [2:0] hungry);
    logic [2:0] urgent;
    urgent = req & hungry;
    if (urgent[0]) return 2'd0;
    if (urgent[1]) return 2'd1;
    if (urgent[2]) return 2'd2;
    if (PRIO_MODE == 1) return pick_rr(req, ptr);
    return pick_fixed(req);
  endfunction

`ifdef RIB_ARB_STARVE_GUARD_EN
  logic [3:0] wait_q [3];

  for (genvar m = 0; m < 3; m++) begin : g_starve
    assign starved[m] = (wait_q[m] == 4'hF);

    // Count cycles a master requests without owning the bus; clear on grant.
    // NOTE: small control arrays like this are reset explicitly because their
    // value steers arbitration right after reset; data RAMs would not be.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wait_q[m] <= 4'h0;
      end else if (load_en && (load_idx == 2'(m))) begin
        wait_q[m] <= 4'h0;
      end else if (m_req_i[m] && !(grant_vld_q && (grant_q == 2'(m)))
                   && (wait_q[m] != 4'hF)) begin
        wait_q[m] <= wait_q[m] + 4'h1;
      end
    end
  end
`else
  assign starved = 3'b000;
`endif

  // Decide whether the owner releases the bus and who would be loaded next.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req_others = m_req_i & ~onehot(grant_q);
    lock_kept  = m_lock_i[grant_q] & ~|(starved & ~onehot(grant_q));
    grant_rel  = 1'b0;
    load_en    = 1'b0;
    load_idx   = GRANT_NONE;
    if (state_q == ST_IDLE) begin
      load_en  = |m_req_i;
      load_idx = arbitrate(m_req_i, ptr_q, starved);
    end else if (state_q == ST_BUSY) begin
      // An abandoned request counts as an unlocked completion.
      grant_rel = ~m_req_i[grant_q] | (bus_ack_i & ~lock_kept);
      load_en   = grant_rel & (|req_others);
      load_idx  = arbitrate(req_others, ptr_q, starved);
    end
  end

  // Sequencer FSM with registered grant, error and timeout outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_NONE;
      grant_vld_q <= 1'b0;
      err_ack_q   <= 3'b000;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
      ptr_q       <= 2'd1;
    end else begin
      // Error ack and timeout are single-cycle pulses.
      err_ack_q <= 3'b000;
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            state_q     <= ST_BUSY;
            grant_q     <= load_idx;
            grant_vld_q <= 1'b1;
            ptr_q       <= load_idx;
            wdog_q      <= '0;
          end
        end
        ST_BUSY: begin
          if (grant_rel) begin
            if (load_en) begin
              // Hand over directly, no IDLE bubble.
              grant_q <= load_idx;
              ptr_q   <= load_idx;
              wdog_q  <= '0;
            end else begin
              state_q     <= ST_IDLE;
              grant_q     <= GRANT_NONE;
              grant_vld_q <= 1'b0;
            end
          end else if (bus_ack_i) begin
            // Locked transfer completed: keep the bus, restart the watchdog.
            wdog_q <= '0;
          end else if (wdog_q == WDOG_LAST) begin
            // The grant stays visible on grant_o to name the offender.
            state_q     <= ST_TOUT;
            grant_vld_q <= 1'b0;
            timeout_q   <= 1'b1;
            err_ack_q   <= onehot(grant_q);
            ptr_q       <= grant_q;
          end else begin
            wdog_q <= wdog_q + CNT_W'(1);
          end
        end
        ST_TOUT: begin
          state_q <= ST_IDLE;
          grant_q <= GRANT_NONE;
          wdog_q  <= '0;
        end
        default: begin
          state_q     <= ST_IDLE;
          grant_q     <= GRANT_NONE;
          grant_vld_q <= 1'b0;
          wdog_q      <= '0;
        end
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign grant_vld_o = grant_vld_q;
  assign err_ack_o   = err_ack_q;
  assign timeout_o   = timeout_q;

  // Stall the pipeline whenever a non-fetch master wants or owns the bus.
  assign hold_flag_o = rst & (m_req_i[0] | m_req_i[2] |
                              (grant_vld_q & (grant_q != 2'd1)));

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: drives a fixed-priority and a round-robin arbiter with the
// same stimulus and compares both against a bus-ownership model kept here.
module tb_rib_arbiter;

  localparam int TOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] m_req;
  logic [2:0] m_lock;
  logic       bus_ack;

  logic [1:0] d_grant [2];
  logic       d_vld   [2];
  logic       d_hold  [2];
  logic [2:0] d_err   [2];
  logic       d_to    [2];

  int total = 0;
  int bad   = 0;
  string name [2] = '{"fp", "rr"};

  always #5 clk = ~clk;

  rib_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(TOUT), .CNT_W(16)) dut_fp (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_lock_i(m_lock),
    .bus_ack_i(bus_ack), .grant_o(d_grant[0]), .grant_vld_o(d_vld[0]),
    .hold_flag_o(d_hold[0]), .err_ack_o(d_err[0]), .timeout_o(d_to[0]));

  rib_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(TOUT), .CNT_W(16)) dut_rr (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_lock_i(m_lock),
    .bus_ack_i(bus_ack), .grant_o(d_grant[1]), .grant_vld_o(d_vld[1]),
    .hold_flag_o(d_hold[1]), .err_ack_o(d_err[1]), .timeout_o(d_to[1]));

  // Model of who owns the bus: owner -1 = nobody. Index 0 = fixed, 1 = rr.
  int m_owner   [2];
  bit m_tout    [2];
  int m_tout_who[2];
  int m_busy    [2];   // BUSY cycles since the transfer started or last ack
  int m_last    [2];   // last granted master
  int m_wait    [2][3];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_tout[k]  = 1'b0;
      m_busy[k]  = 0;
      m_last[k]  = 1;
      for (int n = 0; n < 3; n++) m_wait[k][n] = 0;
    end
  endfunction

  function automatic int pick(int k, logic [2:0] req);
    int order [3] = '{0, 2, 1};
`ifdef RIB_ARB_STARVE_GUARD_EN
    for (int n = 0; n < 3; n++) if (req[n] && m_wait[k][n] == 15) return n;
`endif
    if (k == 0) begin
      for (int i = 0; i < 3; i++) if (req[order[i]]) return order[i];
    end else begin
      for (int s = 1; s <= 3; s++) if (req[(m_last[k] + s) % 3]) return (m_last[k] + s) % 3;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge with the inputs seen before it.
  function automatic void model_step(int k, logic [2:0] req, logic [2:0] lock,
                                     logic ack);
    int         g;
    int         win = -1;
    int         owner_before = m_owner[k];
    bit         lock_ok;
    logic [2:0] rest;
    if (m_tout[k]) begin
      m_tout[k] = 1'b0;
    end else if (m_owner[k] < 0) begin
      if (req != 3'b000) win = pick(k, req);
    end else begin
      g       = m_owner[k];
      lock_ok = lock[g];
`ifdef RIB_ARB_STARVE_GUARD_EN
      for (int n = 0; n < 3; n++) if (n != g && m_wait[k][n] == 15) lock_ok = 1'b0;
`endif
      if (!req[g] || (ack && !lock_ok)) begin
        rest    = req;
        rest[g] = 1'b0;
        if (rest != 3'b000) win = pick(k, rest);
        else m_owner[k] = -1;
      end else if (ack) begin
        m_busy[k] = 0;
      end else if (m_busy[k] == TOUT - 1) begin
        m_tout[k]     = 1'b1;
        m_tout_who[k] = g;
        m_owner[k]    = -1;
        m_last[k]     = g;
      end else begin
        m_busy[k]++;
      end
    end
`ifdef RIB_ARB_STARVE_GUARD_EN
    for (int n = 0; n < 3; n++) begin
      if (win == n) m_wait[k][n] = 0;
      else if (req[n] && owner_before != n && m_wait[k][n] < 15) m_wait[k][n]++;
    end
`endif
    if (win >= 0) begin
      m_owner[k] = win;
      m_last[k]  = win;
      m_busy[k]  = 0;
    end
  endfunction

  function automatic int exp_grant(int k);
    if (m_tout[k]) return m_tout_who[k];
    if (m_owner[k] < 0) return 3;
    return m_owner[k];
  endfunction

  function automatic bit exp_hold(int k, logic [2:0] req);
    return req[0] || req[2] || (m_owner[k] >= 0 && m_owner[k] != 1);
  endfunction

  task automatic compare_regs();
    for (int k = 0; k < 2; k++) begin
      check({name[k], ".grant"}, 32'(d_grant[k]), 32'(exp_grant(k)));
      check({name[k], ".vld"},   32'(d_vld[k]),   32'(m_owner[k] >= 0));
      check({name[k], ".err"},   32'(d_err[k]),
            m_tout[k] ? (32'd1 << m_tout_who[k]) : 32'd0);
      check({name[k], ".tout"},  32'(d_to[k]),    32'(m_tout[k]));
    end
  endtask

  // One cycle: apply inputs, check the combinational hold, clock, check.
  task automatic tick(input logic [2:0] req, input logic [2:0] lock,
                      input logic ack);
    m_req   = req;
    m_lock  = lock;
    bus_ack = ack;
    #1;
    for (int k = 0; k < 2; k++)
      check({name[k], ".hold"}, 32'(d_hold[k]), 32'(exp_hold(k, req)));
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, req, lock, ack);
    #1;
    compare_regs();
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({name[k], ".", tag, ".grant"}, 32'(d_grant[k]), 32'd3);
      check({name[k], ".", tag, ".vld"},   32'(d_vld[k]),   32'd0);
      check({name[k], ".", tag, ".err"},   32'(d_err[k]),   32'd0);
      check({name[k], ".", tag, ".tout"},  32'(d_to[k]),    32'd0);
      check({name[k], ".", tag, ".hold"},  32'(d_hold[k]),  32'd0);
    end
  endtask

  // Full reset across a clock edge; leaves time at posedge + 1.
  task automatic do_reset();
    m_req   = 3'b101;
    m_lock  = 3'b000;
    bus_ack = 1'b0;
    rst     = 1'b0;
    #1;
    model_reset();
    check_reset_values("rst");
    @(posedge clk);
    #1;
    m_req = 3'b000;
    rst   = 1'b1;
  endtask

  // Reset pulse between clock edges; entered and left away from posedge.
  task automatic mid_reset();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_values("midrst");
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] rq;
    logic [2:0] lk;
    logic       ak;
    int         rr_seq [3] = '{2, 0, 1};

    rst     = 1'b1;
    m_req   = 3'b000;
    m_lock  = 3'b000;
    bus_ack = 1'b0;
    #2;

    // Single fetch request: 1-cycle grant, no hold, ack returns to IDLE.
    do_reset();
    tick(3'b010, 3'b000, 1'b0);
    check("t1.grant", 32'(d_grant[0]), 32'd1);
    check("t1.vld",   32'(d_vld[0]),   32'd1);
    check("t1.hold",  32'(d_hold[0]),  32'd0);
    tick(3'b010, 3'b000, 1'b1);
    check("t1.idle",  32'(d_grant[0]), 32'd3);

    // All request, ack every cycle: fixed 0,2,0,2.. and round-robin 2,0,1..
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(3'b111, 3'b000, 1'b1);
      check($sformatf("t2.fp%0d", i), 32'(d_grant[0]), (i % 2 == 0) ? 32'd0 : 32'd2);
      check($sformatf("t2.rr%0d", i), 32'(d_grant[1]), 32'(rr_seq[i % 3]));
      check($sformatf("t2.hold%0d", i), 32'(d_hold[0]), 32'd1);
    end

    // Locked m2 keeps the bus for 4 acks, then hands to m0 immediately.
    do_reset();
    tick(3'b100, 3'b100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(3'b101, 3'b100, 1'b1);
      check($sformatf("t3.lock%0d", i), 32'(d_grant[0]), 32'd2);
    end
    tick(3'b101, 3'b000, 1'b1);
    check("t3.fp.next", 32'(d_grant[0]), 32'd0);
    check("t3.rr.next", 32'(d_grant[1]), 32'd0);

    // Watchdog: 8 silent BUSY cycles, then one TOUT cycle, then IDLE.
    do_reset();
    tick(3'b001, 3'b000, 1'b0);
    for (int i = 0; i < 7; i++) tick(3'b001, 3'b000, 1'b0);
    check("t4.busy8", 32'(d_to[0]), 32'd0);
    tick(3'b001, 3'b000, 1'b0);
    check("t4.tout",  32'(d_to[0]),  32'd1);
    check("t4.err",   32'(d_err[0]), 32'b001);
    check("t4.vld",   32'(d_vld[0]), 32'd0);
    tick(3'b001, 3'b000, 1'b0);
    check("t4.tout1", 32'(d_to[0]),    32'd0);
    check("t4.idle",  32'(d_grant[0]), 32'd3);
    tick(3'b001, 3'b000, 1'b0);
    check("t4.regrant", 32'(d_grant[0]), 32'd0);

    // Ack on the 8th BUSY cycle beats the watchdog.
    do_reset();
    tick(3'b001, 3'b000, 1'b0);
    for (int i = 0; i < 7; i++) tick(3'b001, 3'b000, 1'b0);
    tick(3'b001, 3'b000, 1'b1);
    check("t5.notout", 32'(d_to[0]),    32'd0);
    check("t5.idle",   32'(d_grant[0]), 32'd3);

    // Asynchronous reset mid-BUSY, then a fetch request is granted in 1 cycle.
    do_reset();
    tick(3'b100, 3'b000, 1'b0);
    mid_reset();
    tick(3'b010, 3'b000, 1'b0);
    check("t6.grant", 32'(d_grant[0]), 32'd1);
    check("t6.vld",   32'(d_vld[0]),   32'd1);

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    rq = 3'b000;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
      lk = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      ak = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 249) == 0) mid_reset();
      else tick(rq, lk, ak);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Registered arbiter and transaction sequencer for the RIB bus.
- Shares the single bus path between three masters: m0 = ex/mem unit, m1 = instruction fetch (default owner), m2 = JTAG/debug.
- Holds a grant until the addressed slave acks. Supports locked back-to-back transfers and drives the pipeline hold flag.
- Feeds the bus mux select (`grant_o`) and replaces the combinational next-grant logic of the bus.

Parameters:
- `PRIO_MODE`, default 0: 0 = fixed priority m0 > m2 > m1; 1 = round-robin starting after the last granted master.
- `TIMEOUT_CYCLES`, default 256: cycles in BUSY without ack before a forced release. Legal range 2..65535.
- `CNT_W`, default 16: watchdog counter width. Must hold `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-low reset
- `m_req_i`  in  3  per-master request, bit n = master n
- `m_lock_i`  in  3  per-master lock: keep the grant after ack
- `bus_ack_i`  in  1  ack from the slave currently addressed by the granted master (post-mux)
- `grant_o`  out  2  encoded granted master: 0, 1 or 2; 3 = none
- `grant_vld_o`  out  1  `grant_o` is valid and the bus mux is driven
- `hold_flag_o`  out  1  pipeline stall request (HoldEnable = 1)
- `err_ack_o`  out  3  one-cycle error ack to master n on timeout
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (`rst` = 0, async): state = IDLE, `grant_o` = 3, `grant_vld_o` = 0, `err_ack_o` = 0, `timeout_o` = 0, watchdog = 0, round-robin pointer = 1 (last = m1). `hold_flag_o` = 0 while in reset.
- States: IDLE, BUSY, TOUT.
- IDLE:
  - If `m_req_i` ≠ 0, winner = arbitrate(`m_req_i`).
  - Next cycle: BUSY, `grant_o` = winner, `grant_vld_o` = 1.
  - Request-to-grant latency is 1 cycle.
- BUSY:
  - `grant_o` is stable.
  - Watchdog increments each cycle and clears on state entry and on every ack.
- Transfer done (`bus_ack_i` and `m_req_i[grant]` both 1):
  - If `m_lock_i[grant]` = 1: stay BUSY with the same grant, ignoring other requesters.
  - Else if other requests are pending: arbitrate among `m_req_i` with the current grant masked, and load the winner directly (no IDLE bubble).
  - Else: go to IDLE, `grant_o` = 3, `grant_vld_o` = 0.
- Granted master drops `m_req_i` without ack (abandon): treated as done without lock, same re-arbitration.
- Watchdog reaches `TIMEOUT_CYCLES` − 1 with no ack: go to TOUT.
- TOUT (exactly 1 cycle):
  - `timeout_o` = 1, `err_ack_o[grant]` = 1, `grant_vld_o` = 0.
  - Pointer advances past the offending master.
  - Next state is IDLE. A still-requesting offender is re-arbitrated normally.
- Arbitration:
  - `PRIO_MODE` 0: first set bit in order 0, 2, 1.
  - `PRIO_MODE` 1: search (ptr+1) mod 3, (ptr+2) mod 3, ptr. The pointer updates to the winner on every grant load.
- Simultaneous ack and watchdog expiry in the same cycle: ack wins, no timeout.
- Lock asserted during TOUT is ignored.
- `hold_flag_o` (combinational) = `m_req_i[0]` | `m_req_i[2]` | (`grant_vld_o` & `grant_o` ≠ 1).
- Gating: `bus_ack_i` is ignored outside BUSY. `err_ack_o` is never asserted together with `grant_vld_o`.
- Reset asserted mid-transfer: immediate return to reset values; no ack or err is generated.

Optional Feature:
- Macro: `RIB_ARB_STARVE_GUARD_EN`.
- Defined:
  - Per-master 4-bit wait counter, incremented each cycle the master requests but is not granted.
  - At 15, that master wins the next arbitration regardless of `PRIO_MODE`; lowest index wins on ties.
  - The counter clears on grant.
  - A lock is broken after the current ack if another master's counter is 15.
- Not defined: no counters; arbitration is exactly as above.

Test Plan:
- Reset release, `m_req_i` = 3'b010 at cycle 0 → `grant_o` = 1, `grant_vld_o` = 1 at cycle 1, `hold_flag_o` = 0; slave ack → IDLE next cycle, `grant_o` = 3.
- `PRIO_MODE` 0, `m_req_i` = 3'b111 held, ack every cycle → grant sequence 0,2,0,2,…; m1 never granted while m0/m2 request; `hold_flag_o` = 1 throughout.
- `PRIO_MODE` 1, `m_req_i` = 3'b111, ack every cycle, no lock → grants 2,0,1,2,0,1 from reset (pointer = 1).
- m2 granted with `m_lock_i[2]` = 1, 4 acks, m0 requesting → grant stays 2 for all 4 transfers; drop lock → next grant is 0 one cycle after the ack.
- `TIMEOUT_CYCLES` = 8, m0 granted, no ack → TOUT on the 8th BUSY cycle: `timeout_o` = 1, `err_ack_o` = 3'b001 for 1 cycle, then IDLE; ack applied on cycle 8 instead → no timeout.
- Assert `rst` = 0 mid-BUSY (async, between clock edges) → `grant_vld_o` = 0, `grant_o` = 3 immediately; after release, m1 request is granted in 1 cycle.
